input_debouncer: RTL

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/input_debouncer.sv
// Two-channel switch debouncer: each raw input is synchronized, then filtered by a
// four-state FSM that accepts a level only after DEBOUNCE_CYCLES stable samples.

module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       level,
    output logic       pulse,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'b00,
        ST_CHK_HIGH = 2'b01,
        ST_HIGH     = 2'b10,
        ST_CHK_LOW  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_s1_r;
    logic             sync_s2_r;
    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             level_r;
    logic             level_next_s;
    logic             pulse_r;
    logic             pulse_next_s;

    // Synchronizer, FSM state, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_s1_r <= 1'b0;
            sync_s2_r <= 1'b0;
            state_r   <= ST_LOW;
            cnt_r     <= CNT_ZERO;
            level_r   <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            sync_s1_r <= btn;
            sync_s2_r <= sync_s1_r;
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            level_r   <= level_next_s;
            pulse_r   <= pulse_next_s;
        end
    end

    // Next-state, counter and output decode; the counter stops at CNT_LAST
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        pulse_next_s = 1'b0;
        level_next_s = 1'b0;
        case (state_r)
            ST_LOW: begin
                if (sync_s2_r) begin
                    state_next_s = ST_CHK_HIGH;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    state_next_s = ST_LOW;
                    cnt_next_s   = CNT_ZERO;
                end
            end
            ST_CHK_HIGH: begin
                if (!sync_s2_r) begin
                    state_next_s = ST_LOW;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_HIGH;
                    cnt_next_s   = CNT_ZERO;
                    pulse_next_s = 1'b1;
                end else begin
                    state_next_s = ST_CHK_HIGH;
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_s2_r) begin
                    state_next_s = ST_CHK_LOW;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    state_next_s = ST_HIGH;
                    cnt_next_s   = CNT_ZERO;
                end
            end
            ST_CHK_LOW: begin
                if (sync_s2_r) begin
                    state_next_s = ST_HIGH;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_LOW;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = ST_CHK_LOW;
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_LOW;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
        // Output is high exactly in HIGH and CHK_LOW, which is bit 1 of the encoding
        if ((state_next_s == ST_HIGH) || (state_next_s == ST_CHK_LOW)) begin
            level_next_s = 1'b1;
        end else begin
            level_next_s = 1'b0;
        end
    end

    assign level = level_r;
    assign pulse = pulse_r;
    assign state = state_r;

endmodule

module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_a,
    input  logic       btn_b,
    output logic       A,
    output logic       B,
    output logic       pulse_a,
    output logic       pulse_b,
    output logic [1:0] state_a,
    output logic [1:0] state_b
);

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_a (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_a),
        .level (A),
        .pulse (pulse_a),
        .state (state_a)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_b (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_b),
        .level (B),
        .pulse (pulse_b),
        .state (state_b)
    );

endmodule
